// File: rtl/alu_system_pkg.sv
// alu_system_pkg: shared encodings for the Project 1 datapath
package alu_system_pkg;
  typedef enum logic [1:0] {FUN_CLR, FUN_LOAD, FUN_DEC, FUN_INC} fun_e;
  typedef enum logic [3:0] {
    OP_A, OP_B, OP_NOTA, OP_NOTB, OP_ADD, OP_SUB, OP_CMP, OP_AND,
    OP_OR, OP_NAND, OP_XOR, OP_LSL, OP_LSR, OP_ASL, OP_ASR, OP_CSR
  } alu_op_e;
  localparam logic [1:0] SRC_ALU = 2'b00, SRC_MEM = 2'b01, SRC_IR = 2'b10, SRC_ARF = 2'b11;
  localparam int AR_I = 0, SP_I = 1, PCP_I = 2, PC_I = 3;
endpackage

// File: rtl/alu_system_address_register_file.sv
// address_register_file: AR, SP, PCpast, PC stored in read-select order
module address_register_file
  import alu_system_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] out_a_sel,
  input  logic [1:0] out_b_sel,
  input  logic [1:0] fun_sel,
  input  logic [3:0] r_sel,
  input  logic [7:0] d,
  output logic [7:0] out_a,
  output logic [7:0] out_b
);
  logic [7:0] regs [4];
  logic [3:0] en;
  assign en[AR_I]  = r_sel[2];
  assign en[SP_I]  = r_sel[1];
  assign en[PCP_I] = r_sel[0];
  assign en[PC_I]  = r_sel[3];
  genvar i;
  for (i = 0; i < 4; i++) begin : g_reg
    fun_reg #(.W(8)) u_reg (.clk, .rst_n, .en(en[i]), .fun(fun_sel), .d, .q(regs[i]));
  end
  assign out_a = regs[out_a_sel];
  assign out_b = regs[out_b_sel];
endmodule

// File: rtl/alu_system_alu.sv
// alu: combinational 8-bit ALU with a ZCNO flag register loaded every cycle
module alu
  import alu_system_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] res,
  output logic [3:0] zcno
);
  logic [3:0] zcno_q, zcno_d;
  logic [8:0] sum, diff;
  logic [7:0] fr;
  logic       c, o;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = a;
    c    = zcno_q[2];
    o    = zcno_q[0];
    case (op)
      OP_A:    res = a;
      OP_B:    res = b;
      OP_NOTA: res = ~a;
      OP_NOTB: res = ~b;
      OP_ADD:  begin res = sum[7:0]; c = sum[8]; o = ~(a[7] ^ b[7]) & (a[7] ^ sum[7]); end
      OP_SUB:  begin res = diff[7:0]; c = diff[8]; o = (a[7] ^ b[7]) & (a[7] ^ diff[7]); end
      OP_CMP:  begin res = a; c = diff[8]; o = (a[7] ^ b[7]) & (a[7] ^ diff[7]); end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NAND: res = ~(a & b);
      OP_XOR:  res = a ^ b;
      OP_LSL:  begin res = {a[6:0], 1'b0}; c = a[7]; end
      OP_LSR:  begin res = {1'b0, a[7:1]}; c = a[0]; end
      OP_ASL:  begin res = {a[6:0], 1'b0}; c = a[7]; o = a[7] ^ a[6]; end
      OP_ASR:  begin res = {a[7], a[7:1]}; c = a[0]; end
      OP_CSR:  begin res = {a[0], a[7:1]}; c = a[0]; end
    endcase
    fr     = op == OP_CMP ? diff[7:0] : res;
    zcno_d = {fr == 8'h00, c, fr[7], o};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) zcno_q <= '0;
    else zcno_q <= zcno_d;
  assign zcno = zcno_q;
endmodule

// File: rtl/alu_system_fun_reg.sv
// fun_reg: width-parameterised clear/load/dec/inc register with enable
module fun_reg
  import alu_system_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   fun,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb
    q_d = !en ? q_q : fun == FUN_CLR ? '0 : fun == FUN_LOAD ? d : fun == FUN_DEC ? q_q - 1'b1 : q_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/alu_system_instruction_register.sv
// instruction_register: 16-bit IR; a load replaces only the half chosen by lh
module instruction_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lh,
  input  logic [1:0]  fun_sel,
  input  logic [7:0]  d,
  output logic [15:0] ir
);
  logic [15:0] d_w;
  assign d_w = lh ? {d, ir[7:0]} : {ir[15:8], d};
  fun_reg #(.W(16)) u_ir (.clk, .rst_n, .en, .fun(fun_sel), .d(d_w), .q(ir));
endmodule

// File: rtl/alu_system_memory.sv
// memory: 256x8, combinational read gated by active-low chip select, synchronous write
module memory (
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       cs,
  output logic [7:0] dout
);
  logic [7:0] mem_q [256];
  always_ff @(posedge clk)
    if (!cs && wr) mem_q[addr] <= din;
  assign dout = cs ? 8'h00 : mem_q[addr];
endmodule

// File: rtl/alu_system_register_file.sv
// register_file: T1-T4 at indices 0-3 and R1-R4 at 4-7, so the read select indexes directly
module register_file (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] out_a_sel,
  input  logic [2:0] out_b_sel,
  input  logic [1:0] fun_sel,
  input  logic [3:0] r_sel,
  input  logic [3:0] t_sel,
  input  logic [7:0] d,
  output logic [7:0] out_a,
  output logic [7:0] out_b
);
  logic [7:0] regs [8];
  logic [7:0] en;
  assign en = {r_sel[0], r_sel[1], r_sel[2], r_sel[3], t_sel[0], t_sel[1], t_sel[2], t_sel[3]};
  genvar i;
  for (i = 0; i < 8; i++) begin : g_reg
    fun_reg #(.W(8)) u_reg (.clk, .rst_n, .en(en[i]), .fun(fun_sel), .d, .q(regs[i]));
  end
  assign out_a = regs[out_a_sel];
  assign out_b = regs[out_b_sel];
endmodule

// File: rtl/alu_system.sv
// alu_system: Project 1 datapath with every control as a primary input and debug taps on all buses
module alu_system
  import alu_system_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  RF_OutASel,
  input  logic [2:0]  RF_OutBSel,
  input  logic [1:0]  RF_FunSel,
  input  logic [3:0]  RF_RSel,
  input  logic [3:0]  RF_TSel,
  input  logic [3:0]  ALU_FunSel,
  input  logic [1:0]  ARF_OutASel,
  input  logic [1:0]  ARF_OutBSel,
  input  logic [1:0]  ARF_FunSel,
  input  logic [3:0]  ARF_RSel,
  input  logic        IR_LH,
  input  logic        IR_Enable,
  input  logic [1:0]  IR_Funsel,
  input  logic        Mem_WR,
  input  logic        Mem_CS,
  input  logic [1:0]  MuxASel,
  input  logic [1:0]  MuxBSel,
  input  logic        MuxCSel,
  output logic [7:0]  out,
  output logic [7:0]  p_RF_O1,
  output logic [7:0]  p_RF_O2,
  output logic [7:0]  p_ALU_Out,
  output logic [7:0]  p_ARF_OutA,
  output logic [7:0]  p_MEM_Address,
  output logic [7:0]  p_MEM_Out,
  output logic [7:0]  p_MUXA_Out,
  output logic [7:0]  p_MUXB_Out,
  output logic [7:0]  p_MUXC_Out,
  output logic [7:0]  p_ALU_ZCNO,
  output logic [15:0] p_IR_Out
);
  logic [7:0]  rf_a, rf_b, arf_a, arf_b, alu_out, mem_out, mux_a, mux_b, mux_c;
  logic [3:0]  zcno;
  logic [15:0] ir;
  assign mux_a = MuxASel == SRC_ALU ? alu_out : MuxASel == SRC_MEM ? mem_out : MuxASel == SRC_IR ? ir[7:0] : arf_a;
  assign mux_b = MuxBSel == SRC_ALU ? alu_out : MuxBSel == SRC_MEM ? mem_out : MuxBSel == SRC_IR ? ir[7:0] : arf_a;
  assign mux_c = MuxCSel ? arf_a : rf_a;
  register_file u_rf (
    .clk(Clock), .rst_n(Reset), .out_a_sel(RF_OutASel), .out_b_sel(RF_OutBSel), .fun_sel(RF_FunSel),
    .r_sel(RF_RSel), .t_sel(RF_TSel), .d(mux_a), .out_a(rf_a), .out_b(rf_b)
  );
  address_register_file u_arf (
    .clk(Clock), .rst_n(Reset), .out_a_sel(ARF_OutASel), .out_b_sel(ARF_OutBSel), .fun_sel(ARF_FunSel),
    .r_sel(ARF_RSel), .d(mux_b), .out_a(arf_a), .out_b(arf_b)
  );
  instruction_register u_ir (
    .clk(Clock), .rst_n(Reset), .en(IR_Enable), .lh(IR_LH), .fun_sel(IR_Funsel), .d(mem_out), .ir
  );
  alu u_alu (.clk(Clock), .rst_n(Reset), .a(mux_c), .b(rf_b), .op(ALU_FunSel), .res(alu_out), .zcno);
  memory u_mem (.clk(Clock), .addr(arf_b), .din(alu_out), .wr(Mem_WR), .cs(Mem_CS), .dout(mem_out));
  assign out           = alu_out;
  assign p_RF_O1       = rf_a;
  assign p_RF_O2       = rf_b;
  assign p_ALU_Out     = alu_out;
  assign p_ARF_OutA    = arf_a;
  assign p_MEM_Address = arf_b;
  assign p_MEM_Out     = mem_out;
  assign p_MUXA_Out    = mux_a;
  assign p_MUXB_Out    = mux_b;
  assign p_MUXC_Out    = mux_c;
  assign p_ALU_ZCNO    = {4'b0000, zcno};
  assign p_IR_Out      = ir;
endmodule

// File: tb/tb_alu_system.sv
// tb_alu_system: directed vectors; expectations queued by stimulus, compared by a negedge monitor
module tb_alu_system;
  logic        Clock = 1'b0, Reset;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel, MuxASel, MuxBSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel;
  logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel;
  logic [7:0]  out, p_RF_O1, p_RF_O2, p_ALU_Out, p_ARF_OutA, p_MEM_Address, p_MEM_Out;
  logic [7:0]  p_MUXA_Out, p_MUXB_Out, p_MUXC_Out, p_ALU_ZCNO;
  logic [15:0] p_IR_Out;
  alu_system dut (
    .Clock(Clock), .Reset(Reset), .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel), .ARF_OutASel(ARF_OutASel),
    .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel), .IR_LH(IR_LH),
    .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .out(out), .p_RF_O1(p_RF_O1), .p_RF_O2(p_RF_O2),
    .p_ALU_Out(p_ALU_Out), .p_ARF_OutA(p_ARF_OutA), .p_MEM_Address(p_MEM_Address), .p_MEM_Out(p_MEM_Out),
    .p_MUXA_Out(p_MUXA_Out), .p_MUXB_Out(p_MUXB_Out), .p_MUXC_Out(p_MUXC_Out), .p_ALU_ZCNO(p_ALU_ZCNO),
    .p_IR_Out(p_IR_Out)
  );
  always #5 Clock = ~Clock;
  localparam int T_OUT = 0, T_RF1 = 1, T_RF2 = 2, T_ARFA = 3, T_ADDR = 4, T_MEM = 5, T_ZCNO = 6, T_C = 7, T_IR = 8;
  typedef struct {
    int          tap;
    logic [15:0] want;
    string       name;
  } chk_t;
  chk_t sb[$];
  int n_pass = 0, n_total = 0;
  function automatic logic [15:0] tap_val(int t);
    case (t)
      T_OUT:   return {8'h00, out};
      T_RF1:   return {8'h00, p_RF_O1};
      T_RF2:   return {8'h00, p_RF_O2};
      T_ARFA:  return {8'h00, p_ARF_OutA};
      T_ADDR:  return {8'h00, p_MEM_Address};
      T_MEM:   return {8'h00, p_MEM_Out};
      T_ZCNO:  return {8'h00, p_ALU_ZCNO};
      T_C:     return {15'h0000, p_ALU_ZCNO[2]};
      default: return p_IR_Out;
    endcase
  endfunction
  always @(negedge Clock)
    while (sb.size() > 0) begin
      chk_t c;
      logic [15:0] got;
      c = sb.pop_front();
      got = tap_val(c.tap);
      n_total++;
      if (got === c.want) n_pass++;
      else $display("FAIL %s: got %h, expected %h", c.name, got, c.want);
    end
  task automatic expect_tap(input int t, input logic [15:0] want, input string name);
    chk_t c;
    c.tap = t;
    c.want = want;
    c.name = name;
    sb.push_back(c);
  endtask
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic hold();
    @(negedge Clock);
    #1;
  endtask
  task automatic idle();
    RF_RSel = 4'b0000;
    RF_TSel = 4'b0000;
    ARF_RSel = 4'b0000;
    IR_Enable = 1'b0;
    Mem_CS = 1'b1;
    Mem_WR = 1'b0;
  endtask
  task automatic rf_const(input logic [2:0] r, input logic [7:0] v);
    logic [3:0] m;
    m = 4'b1000 >> r[1:0];
    idle();
    RF_OutASel = r;
    if (r[2]) RF_RSel = m;
    else RF_TSel = m;
    RF_FunSel = 2'b00;
    step();
    for (int i = 7; i >= 0; i--) begin
      RF_FunSel = 2'b01;
      MuxASel = 2'b00;
      MuxCSel = 1'b0;
      ALU_FunSel = 4'b1011;
      step();
      if (v[i]) begin
        RF_FunSel = 2'b11;
        step();
      end
    end
    idle();
  endtask
  task automatic alu_r1_r2(input logic [3:0] op);
    RF_OutASel = 3'b100;
    RF_OutBSel = 3'b101;
    MuxCSel = 1'b0;
    ALU_FunSel = op;
  endtask
  task automatic write_mem_r1();
    alu_r1_r2(4'b0000);
    ARF_OutBSel = 2'b00;
    Mem_CS = 1'b0;
    Mem_WR = 1'b1;
    step();
    Mem_WR = 1'b0;
  endtask
  initial begin
    idle();
    {RF_OutASel, RF_OutBSel, RF_FunSel, ALU_FunSel} = '0;
    {ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel, IR_LH, MuxASel, MuxBSel, MuxCSel} = '0;
    Reset = 1'b0;
    #1;
    expect_tap(T_IR, 16'h0000, "rst_ir");
    expect_tap(T_ZCNO, 16'h0000, "rst_flags");
    expect_tap(T_RF1, 16'h0000, "rst_t1");
    expect_tap(T_ARFA, 16'h0000, "rst_ar");
    expect_tap(T_OUT, 16'h0000, "rst_out");
    expect_tap(T_MEM, 16'h0000, "rst_mem_cs_off");
    hold();
    Reset = 1'b1;
    step();
    rf_const(3'b000, 8'h05);
    RF_OutASel = 3'b000;
    MuxCSel = 1'b0;
    ALU_FunSel = 4'b0000;
    ARF_OutBSel = 2'b00;
    Mem_CS = 1'b0;
    Mem_WR = 1'b1;
    step();
    Mem_WR = 1'b0;
    IR_Enable = 1'b1;
    IR_Funsel = 2'b01;
    IR_LH = 1'b0;
    step();
    idle();
    expect_tap(T_IR, 16'h0005, "ir_low_05");
    hold();
    RF_FunSel = 2'b01;
    MuxASel = 2'b10;
    RF_RSel = 4'b1000;
    step();
    idle();
    RF_OutASel = 3'b100;
    expect_tap(T_RF1, 16'h0005, "r1_from_ir");
    hold();
    rf_const(3'b100, 8'h7F);
    rf_const(3'b101, 8'h01);
    alu_r1_r2(4'b0100);
    expect_tap(T_OUT, 16'h0080, "add_out");
    step();
    expect_tap(T_ZCNO, 16'h0003, "add_flags");
    hold();
    rf_const(3'b100, 8'h03);
    rf_const(3'b101, 8'h05);
    alu_r1_r2(4'b0101);
    expect_tap(T_OUT, 16'h00FE, "sub_out");
    step();
    expect_tap(T_ZCNO, 16'h0006, "sub_flags");
    hold();
    rf_const(3'b100, 8'h22);
    rf_const(3'b101, 8'h22);
    alu_r1_r2(4'b0110);
    expect_tap(T_OUT, 16'h0022, "cmp_out");
    step();
    expect_tap(T_ZCNO, 16'h0008, "cmp_flags");
    hold();
    rf_const(3'b100, 8'h10);
    alu_r1_r2(4'b0000);
    MuxBSel = 2'b00;
    ARF_FunSel = 2'b01;
    ARF_RSel = 4'b0100;
    step();
    idle();
    ARF_OutASel = 2'b00;
    MuxBSel = 2'b11;
    ARF_RSel = 4'b0010;
    step();
    idle();
    ARF_OutASel = 2'b01;
    expect_tap(T_ARFA, 16'h0010, "sp_from_ar");
    hold();
    rf_const(3'b100, 8'hAB);
    alu_r1_r2(4'b0000);
    ARF_OutBSel = 2'b00;
    expect_tap(T_ADDR, 16'h0010, "mem_addr");
    write_mem_r1();
    expect_tap(T_MEM, 16'h00AB, "mem_read");
    hold();
    Mem_CS = 1'b1;
    expect_tap(T_MEM, 16'h0000, "mem_cs_high");
    hold();
    rf_const(3'b100, 8'h34);
    write_mem_r1();
    IR_Enable = 1'b1;
    IR_Funsel = 2'b01;
    IR_LH = 1'b0;
    step();
    idle();
    rf_const(3'b100, 8'h12);
    write_mem_r1();
    IR_Enable = 1'b1;
    IR_LH = 1'b1;
    step();
    idle();
    expect_tap(T_IR, 16'h1234, "ir_halves");
    hold();
    IR_Enable = 1'b1;
    IR_Funsel = 2'b11;
    step();
    idle();
    expect_tap(T_IR, 16'h1235, "ir_inc");
    hold();
    ARF_FunSel = 2'b10;
    ARF_RSel = 4'b1000;
    step();
    idle();
    ARF_OutASel = 2'b11;
    expect_tap(T_ARFA, 16'h00FF, "pc_dec_wrap");
    hold();
    rf_const(3'b110, 8'hFF);
    RF_FunSel = 2'b11;
    RF_RSel = 4'b0010;
    step();
    idle();
    RF_OutBSel = 3'b110;
    expect_tap(T_RF2, 16'h0000, "r3_inc_wrap");
    hold();
    rf_const(3'b100, 8'h81);
    alu_r1_r2(4'b1111);
    expect_tap(T_OUT, 16'h00C0, "csr_out");
    step();
    expect_tap(T_C, 16'h0001, "csr_c");
    hold();
    rf_const(3'b100, 8'h80);
    alu_r1_r2(4'b1110);
    expect_tap(T_OUT, 16'h00C0, "asr_out");
    step();
    expect_tap(T_C, 16'h0000, "asr_c");
    hold();
    ARF_OutASel = 2'b11;
    MuxCSel = 1'b1;
    ALU_FunSel = 4'b0010;
    expect_tap(T_OUT, 16'h0000, "muxc_arf_nota");
    hold();
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    ARF_OutBSel = 2'b00;
    Mem_CS = 1'b0;
    RF_OutASel = 3'b100;
    expect_tap(T_IR, 16'h0000, "async_rst_ir");
    expect_tap(T_RF1, 16'h0000, "async_rst_r1");
    expect_tap(T_ZCNO, 16'h0000, "async_rst_flags");
    expect_tap(T_MEM, 16'h0005, "mem_survives_rst");
    hold();
    Reset = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clock);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d checks left, expected 0", sb.size());
      n_total += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
